// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared definitions for the data-memory responder: data word
//               width, access-size encodings and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int WORD = 64;

  // Access-size encodings (bytes = 1 << size)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_responder_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering for one doubleword.
//               Extracts and zero-extends load data, merges store data into
//               the addressed bytes, and flags misaligned accesses.
// Ports       : size       - access size encoding (SZ_B/H/W/D)
//               offset     - byte offset within the doubleword (addr[2:0])
//               dword      - current doubleword contents
//               wdata      - store data, right-aligned
//               misaligned - offset not a multiple of the access size
//               load_data  - addressed bytes, zero-extended
//               merged     - doubleword with addressed bytes replaced
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [2:0]      offset,
  input  logic [WORD-1:0] dword,
  input  logic [WORD-1:0] wdata,
  output logic            misaligned,
  output logic [WORD-1:0] load_data,
  output logic [WORD-1:0] merged
);

  logic [WORD-1:0] mask;
  logic [5:0]      shamt;

  assign shamt = {offset, 3'b000};

  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        mask       = 64'h0000_0000_0000_00FF;
        misaligned = 1'b0;
      end
      SZ_H: begin
        mask       = 64'h0000_0000_0000_FFFF;
        misaligned = offset[0];
      end
      SZ_W: begin
        mask       = 64'h0000_0000_FFFF_FFFF;
        misaligned = |offset[1:0];
      end
      default: begin
        mask       = '1;
        misaligned = |offset;
      end
    endcase
  end

  assign load_data = (dword >> shamt) & mask;
  assign merged    = (dword & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with a fixed access
//               latency. A request is captured in IDLE, the access happens
//               LAT cycles later, and the response is presented one cycle
//               after the access and held until accepted.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_valid/req_ready        - request handshake
//               req_we/size/addr/wdata     - request fields
//               rsp_valid/rsp_ready        - response handshake
//               rsp_rdata/rsp_err          - registered response payload
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD-1:0] BYTES = WORD'(DEPTH) << 3;

  state_t          state;
  logic [3:0]      cnt;
  logic            acc_done;   // access committed, response goes out next edge
  logic            r_we;
  logic [1:0]      r_size;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] mem [DEPTH];

  logic            in_range;
  logic [IW-1:0]   idx;
  logic            misaligned;
  logic            fault;
  logic            access;
  logic [WORD-1:0] ld_data;
  logic [WORD-1:0] merged;

  // Any nonzero upper address bit lands at or above BYTES and faults here.
  assign in_range = (r_addr < BYTES);
  assign idx      = in_range ? r_addr[IW+2:3] : '0;
  assign fault    = misaligned | ~in_range;
  assign access   = (state == ST_WAIT) && (cnt == 4'd0) && !acc_done;

  mem_lane_align u_lane (
    .size       (r_size),
    .offset     (r_addr[2:0]),
    .dword      (mem[idx]),
    .wdata      (r_wdata),
    .misaligned (misaligned),
    .load_data  (ld_data),
    .merged     (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      acc_done  <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= SZ_B;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            cnt       <= 4'(LAT - 1);
            acc_done  <= 1'b0;
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (acc_done) begin
            acc_done  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (cnt == 4'd0) begin
            acc_done  <= 1'b1;
            rsp_err   <= fault;
            rsp_rdata <= (fault || r_we) ? '0 : ld_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // req_ready is only re-raised here, so no request can be accepted
          // in the same cycle as the response handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (access && r_we && !fault) begin
      mem[idx] <= merged;
    end
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder against a byte-array
//               reference model of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int NBYTE = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [NBYTE];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  function automatic void model_clear();
    for (int i = 0; i < NBYTE; i++) model_mem[i] = 8'h00;
  endfunction

  // Byte-level memory semantics: n = 2**size bytes, little-endian.
  function automatic void model_access(input logic we, input logic [1:0] size,
                                       input logic [63:0] addr, input logic [63:0] wdata,
                                       output logic [63:0] rdata, output logic err);
    int n;
    n     = 1 << size;
    rdata = '0;
    err   = ((addr % 64'(n)) != 0) || (addr >= 64'(NBYTE));
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (we) model_mem[int'(addr) + k] = wdata[8*k +: 8];
        else    rdata[8*k +: 8] = model_mem[int'(addr) + k];
      end
    end
  endfunction

  // Drives one transaction end to end and reports what the DUT returned,
  // the cycle count from acceptance to rsp_valid, and the model expectation.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int lat,
                        output logic [63:0] exp_rdata, output logic exp_err,
                        output bit timeout);
    int w;
    timeout = 0;
    lat     = 0;
    rdata   = '0;
    err     = 1'b0;
    model_access(we, size, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      timeout   = 1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble the request fields: they must be ignored after acceptance.
    req_we    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      timeout = 1;
      return;
    end
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata);
    end
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          to;
    logic        we_l     [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz_l     [7] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
    logic [63:0] ad_l     [7] = '{64'h10, 64'h10, 64'h13, 64'h10, 64'h12, 64'h11, 64'h1FF9};
    logic [63:0] wd_l     [7] = '{64'h0123456789ABCDEF, 64'h0, 64'hAA, 64'h0, 64'h0, 64'h0, 64'hDEAD};
    logic [63:0] want_rd  [7] = '{64'h0, 64'h0123456789ABCDEF, 64'h0, 64'h01234567AAABCDEF,
                                  64'h000000000000AAAB, 64'h0, 64'h0};
    logic        want_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_req(we_l[i], sz_l[i], ad_l[i], wd_l[i], rd, er, lat, erd, eer, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL directed_%0d_timeout: no handshake within bound", i);
        continue;
      end
      if (rd !== want_rd[i]) begin
        errors++; $display("FAIL directed_%0d_rdata: got %h want %h", i, rd, want_rd[i]);
      end
      checks++;
      if (er !== want_err[i]) begin
        errors++; $display("FAIL directed_%0d_err: got %b want %b", i, er, want_err[i]);
      end
      checks++;
      if (lat != LAT + 1) begin
        errors++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, LAT + 1);
      end
    end
    // Doubleword 0 must be untouched by the faulting store above.
    do_req(1'b0, 2'b10, 64'h0, 64'h0, rd, er, lat, erd, eer, to);
    checks++;
    if (to || rd !== 64'h0 || er !== 1'b0) begin
      errors++; $display("FAIL directed_word0_after_fault: got %h/%b want 0/0 (timeout %0d)", rd, er, to);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] erd, held;
    logic        eer;
    int          w;
    model_access(1'b0, 2'b11, 64'h10, 64'h0, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 64'h10; req_wdata = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL bp_timeout: rsp_valid never rose");
      return;
    end
    held = rsp_rdata;
    checks++;
    if (held !== erd) begin
      errors++; $display("FAIL bp_rdata: got %h want %h", held, erd);
    end
    for (int c = 0; c < 5; c++) begin
      // A store that would clobber doubleword 0 if it were wrongly accepted.
      req_valid = (c == 2);
      req_we = 1'b1; req_size = 2'b11; req_addr = 64'h0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_cycle_%0d: valid %b rdata %h ready %b want 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, held);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_after_cycle_%0d: valid %b ready %b want 0 1", c, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, addr, wd;
    logic [1:0]  sz;
    logic        we, er, eer;
    int          lat, kind, n;
    bit          to;
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom);
      sz   = 2'($urandom);
      n    = 1 << sz;
      wd   = {$urandom, $urandom};
      kind = $urandom_range(0, 9);
      if (kind <= 6)      addr = 64'($urandom_range(0, NBYTE - 1)) & ~64'(n - 1);
      else if (kind == 7) addr = 64'($urandom_range(0, NBYTE - 1));
      else if (kind == 8) addr = 64'($urandom_range(NBYTE, 8191));
      else                addr = {$urandom | 32'h1, 32'($urandom_range(0, NBYTE - 1))};
      do_req(we, sz, addr, wd, rd, er, lat, erd, eer, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL rand_%0d_timeout: addr %h no handshake", i, addr);
        continue;
      end
      if (rd !== erd) begin
        errors++; $display("FAIL rand_%0d_rdata: we %b sz %0d addr %h got %h want %h",
                           i, we, sz, addr, rd, erd);
      end
      checks++;
      if (er !== eer) begin
        errors++; $display("FAIL rand_%0d_err: addr %h sz %0d got %b want %b", i, addr, sz, er, eer);
      end
      checks++;
      if (lat != LAT + 1) begin
        errors++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, LAT + 1);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] rd, erd;
    logic        er, eer;
    int          lat;
    bit          to;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 64'h0; req_wdata = 64'hFFFF;
    @(posedge clk);      // acceptance edge
    #1;
    req_valid = 1'b0;
    @(posedge clk);      // one WAIT edge; the access edge has not yet come
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait_during: valid %b ready %b want 0 1", rsp_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_idle: ready %b valid %b want 1 0", req_ready, rsp_valid);
    end
    do_req(1'b0, 2'b11, 64'h0, 64'h0, rd, er, lat, erd, eer, to);
    checks++;
    if (to || rd !== 64'h0 || er !== 1'b0) begin
      errors++; $display("FAIL rst_wait_load0: got %h/%b want 0/0 (timeout %0d)", rd, er, to);
    end
    // Data written before the reset must also be gone.
    do_req(1'b0, 2'b11, 64'h10, 64'h0, rd, er, lat, erd, eer, to);
    checks++;
    if (to || rd !== 64'h0) begin
      errors++; $display("FAIL rst_wait_load10: got %h want 0 (timeout %0d)", rd, to);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
